bpu_update_queue: RTL and testbench
===================================

# bpu_update_queue

Buffers branch-predictor training requests produced by the branch execution unit and replays them into the BHT counter array and the BTB SRAM. It sits between the branch execution unit's scoreboard outputs and the predictor tables. Writes are held while the fetch-side BPU owns the table ports, so training never stalls execution. The queue drains one request per cycle from registered outputs.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `BHTBTB_INDEX_WIDTH`, 9: set-index width (512 sets).
- `BTB_DATA_WIDTH`, 129: 1 valid bit plus 4×32-bit targets.
- `DROP_CNT_WIDTH`, 16: width of the drop counter.

Clock and reset:
- `clock` in 1: single clock.
- `reset` in 1: synchronous reset, active-high.

BHT request inputs, from the branch unit:
- `in_bht_write_enable` in 1
- `in_bht_write_index` in BHTBTB_INDEX_WIDTH
- `in_bht_write_counter_select` in 2
- `in_bht_write_inc` in 1
- `in_bht_write_dec` in 1
- `in_bht_valid_in` in 1

BTB request inputs, from the branch unit:
- `in_btb_we` in 1
- `in_btb_wmask` in BTB_DATA_WIDTH
- `in_btb_write_index` in BHTBTB_INDEX_WIDTH
- `in_btb_din` in BTB_DATA_WIDTH

Port arbitration:
- `bpu_port_busy` in 1: the fetch BPU is reading the tables this cycle, so no drain.

Outputs to the tables (all registered):
- `bht_write_enable`, `bht_write_index`, `bht_write_counter_select`, `bht_write_inc`, `bht_write_dec`, `bht_valid_in`: same widths as the BHT inputs.
- `btb_ce`, `btb_we` out 1.
- `btb_wmask`, `btb_din` out BTB_DATA_WIDTH.
- `btb_write_index` out BHTBTB_INDEX_WIDTH.

Status outputs:
- `occupancy` out clog2(DEPTH)+1: current number of queue entries.
- `full` out 1: equals (occupancy == DEPTH).
- `drop_count` out DROP_CNT_WIDTH: saturating count of dropped requests.

## Operation
- **Request definition:** a request exists in a cycle when `in_bht_write_enable | in_btb_we`. One request is one entry holding both the BHT and BTB fields.
- **Enqueue:** the request is written at the tail when the queue has room after this cycle's dequeue. Room is defined as `occupancy < DEPTH`, or `occupancy == DEPTH` with a dequeue in the same cycle.
- **Drop:** with no room, the new request is discarded and `drop_count` increments. The counter saturates at all-ones. Queued entries are never overwritten.
- **Dequeue:** occurs when `occupancy != 0` and `!bpu_port_busy`. The head entry is loaded into the output registers.
  - `btb_ce` is set equal to the entry's `btb_we`.
  - BHT outputs carry the entry's BHT fields.
  - An entry with only one table's enable set drives the other table's enable low.
- **Idle outputs:** in any cycle with no dequeue, all output registers load zero, so every enable is a single-cycle pulse.
- **Ordering:** strict FIFO. No coalescing, even for equal indices.
- **Pointers:** head and tail are clog2(DEPTH) bits and wrap modulo DEPTH. `occupancy` is a separate counter:
  - +1 on enqueue only;
  - −1 on dequeue only;
  - unchanged on both or neither.
- **Malformed requests:** an input with `in_bht_write_inc` and `in_bht_write_dec` both set is queued unchanged. The BHT resolves it.

## Timing
- **Latency:** a request accepted in cycle N drives the table outputs in cycle N+1 at the earliest, provided the queue was empty and `bpu_port_busy` was low in cycle N. There is no combinational input-to-output path.
- **Throughput:** one enqueue and one dequeue per cycle, simultaneously.
- **Busy stall:** while `bpu_port_busy` is held high, the outputs stay zero and entries are retained. Draining resumes in the first cycle busy is low.
- **Status timing:** `full` and `occupancy` reflect the registered state at the start of the cycle.
- **Reset:** in any cycle where `reset` is high, the following all become 0 at the next edge, and a pending request in that cycle is not enqueued:
  - head, tail and `occupancy`;
  - `drop_count`;
  - all table outputs.
- **Reset mid-operation:** queued entries are discarded. The entry storage itself is not reset, because the valid state derives from `occupancy`.

## Structure
- **Shared package `bpu_pkg`:**
  - the `bpu_update_t` packed struct (BHT fields plus BTB fields);
  - `BHTBTB_INDEX_WIDTH_DEF`;
  - `BTB_DATA_WIDTH_DEF`.
- **Sub-module:** one generic `sync_fifo` (parameters `WIDTH`, `DEPTH`; ports `push`/`pop`/`dout`/`count`). `bpu_update_queue` adds the room, drop and output-register logic around it.

## Test plan
- **Single request:** BHT-only request, index 0x1A5, sel 2, inc=1, busy=0, cycle 0.
  - Cycle 1: `bht_write_enable`=1, index 0x1A5, sel 2, inc=1.
  - Cycle 1: `btb_we`=0.
  - Cycle 2: all outputs 0.
- **Busy stall:** busy=1 for 5 cycles while 3 requests A, B, C enter.
  - `occupancy`=3 and the outputs stay zero while busy.
  - After busy drops, A, B, C appear on consecutive cycles in order.
- **Full and drop:** busy=1, 6 requests issued; DEPTH=4.
  - `full`=1 and `drop_count`=2.
  - After busy drops, only the first 4 requests drain.
- **Full with simultaneous dequeue:** queue full, busy=0, new request in the same cycle.
  - The request is accepted and `drop_count` is unchanged.
  - `occupancy` stays 4.
- **Wrap-around:** 10 back-to-back requests with busy=0.
  - Each request appears exactly one cycle after it is issued, with its BTB fields (e.g. din with valid bit plus target 0x80000010 in slot 0) intact.
  - No drops.
- **Reset mid-operation:** 3 entries queued, then reset held high for 1 cycle alongside an incoming request.
  - `occupancy`=0 and all outputs 0 afterwards.
  - No stale entry appears later.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types for the branch-predictor update path: one queued training request
// carries both the BHT counter update and the BTB write.
package bpu_pkg;

  localparam int BHTBTB_INDEX_WIDTH_DEF = 9;
  localparam int BTB_DATA_WIDTH_DEF     = 129;

  typedef struct packed {
    logic                              bht_write_enable;
    logic [BHTBTB_INDEX_WIDTH_DEF-1:0] bht_write_index;
    logic [1:0]                        bht_write_counter_select;
    logic                              bht_write_inc;
    logic                              bht_write_dec;
    logic                              bht_valid_in;
    logic                              btb_we;
    logic [BTB_DATA_WIDTH_DEF-1:0]     btb_wmask;
    logic [BHTBTB_INDEX_WIDTH_DEF-1:0] btb_write_index;
    logic [BTB_DATA_WIDTH_DEF-1:0]     btb_din;
  } bpu_update_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with show-ahead read; the caller guarantees push/pop legality.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is deliberately not reset; validity comes from count alone.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= din;
  end

  assign dout = mem[head];

endmodule

// File: rtl/bpu_update_queue.sv
// Holds BHT/BTB training writes while the fetch BPU owns the table ports and
// replays them one per cycle through registered outputs.
module bpu_update_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH              = 4,
  parameter int BHTBTB_INDEX_WIDTH = BHTBTB_INDEX_WIDTH_DEF,
  parameter int BTB_DATA_WIDTH     = BTB_DATA_WIDTH_DEF,
  parameter int DROP_CNT_WIDTH     = 16
) (
  input  logic                          clock,
  input  logic                          reset,

  input  logic                          in_bht_write_enable,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] in_bht_write_index,
  input  logic [1:0]                    in_bht_write_counter_select,
  input  logic                          in_bht_write_inc,
  input  logic                          in_bht_write_dec,
  input  logic                          in_bht_valid_in,

  input  logic                          in_btb_we,
  input  logic [BTB_DATA_WIDTH-1:0]     in_btb_wmask,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] in_btb_write_index,
  input  logic [BTB_DATA_WIDTH-1:0]     in_btb_din,

  input  logic                          bpu_port_busy,

  output logic                          bht_write_enable,
  output logic [BHTBTB_INDEX_WIDTH-1:0] bht_write_index,
  output logic [1:0]                    bht_write_counter_select,
  output logic                          bht_write_inc,
  output logic                          bht_write_dec,
  output logic                          bht_valid_in,

  output logic                          btb_ce,
  output logic                          btb_we,
  output logic [BTB_DATA_WIDTH-1:0]     btb_wmask,
  output logic [BHTBTB_INDEX_WIDTH-1:0] btb_write_index,
  output logic [BTB_DATA_WIDTH-1:0]     btb_din,

  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          full,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  bpu_update_t in_req;
  bpu_update_t head_entry;
  bpu_update_t out_q;

  logic req;
  logic deq;
  logic bypass;
  logic room;
  logic push;
  logic pop;
  logic drop;

  always_comb begin
    in_req                          = '0;
    in_req.bht_write_enable         = in_bht_write_enable;
    in_req.bht_write_index          = in_bht_write_index;
    in_req.bht_write_counter_select = in_bht_write_counter_select;
    in_req.bht_write_inc            = in_bht_write_inc;
    in_req.bht_write_dec            = in_bht_write_dec;
    in_req.bht_valid_in             = in_bht_valid_in;
    in_req.btb_we                   = in_btb_we;
    in_req.btb_wmask                = in_btb_wmask;
    in_req.btb_write_index          = in_btb_write_index;
    in_req.btb_din                  = in_btb_din;
  end

  // An empty, unstalled queue forwards the request straight into the output
  // register so a lone request still reaches the tables one cycle later.
  assign req    = in_bht_write_enable | in_btb_we;
  assign deq    = (occupancy != '0) && !bpu_port_busy;
  assign bypass = req && (occupancy == '0) && !bpu_port_busy;
  assign room   = (occupancy < DEPTH_C) || deq;
  assign push   = req && room && !bypass && !reset;
  assign pop    = deq && !reset;
  assign drop   = req && !room && !reset;

  sync_fifo #(
    .WIDTH ($bits(bpu_update_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_req),
    .dout  (head_entry),
    .count (occupancy)
  );

  always_ff @(posedge clock) begin
    if (reset)       out_q <= '0;
    else if (deq)    out_q <= head_entry;
    else if (bypass) out_q <= in_req;
    else             out_q <= '0;
  end

  always_ff @(posedge clock) begin
    if (reset)                         drop_count <= '0;
    else if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
  end

  assign bht_write_enable         = out_q.bht_write_enable;
  assign bht_write_index          = out_q.bht_write_index;
  assign bht_write_counter_select = out_q.bht_write_counter_select;
  assign bht_write_inc            = out_q.bht_write_inc;
  assign bht_write_dec            = out_q.bht_write_dec;
  assign bht_valid_in             = out_q.bht_valid_in;
  assign btb_ce                   = out_q.btb_we;
  assign btb_we                   = out_q.btb_we;
  assign btb_wmask                = out_q.btb_wmask;
  assign btb_write_index          = out_q.btb_write_index;
  assign btb_din                  = out_q.btb_din;

  assign full = (occupancy == DEPTH_C);

endmodule

// File: tb/tb_bpu_update_queue.sv
// Scenario tasks plus randomized traffic against a queue-based reference model.
module tb_bpu_update_queue;
  import bpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int VW    = $bits(bpu_update_t) + 21;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst;
  logic        busy;
  bpu_update_t drv;

  logic        bht_write_enable;
  logic [8:0]  bht_write_index;
  logic [1:0]  bht_write_counter_select;
  logic        bht_write_inc;
  logic        bht_write_dec;
  logic        bht_valid_in;
  logic        btb_ce;
  logic        btb_we;
  logic [128:0] btb_wmask;
  logic [8:0]  btb_write_index;
  logic [128:0] btb_din;
  logic [2:0]  occupancy;
  logic        full;
  logic [15:0] drop_count;

  bpu_update_t   obs;
  logic [VW-1:0] obs_vec;
  logic [VW-1:0] exp_vec;

  bpu_update_t mq[$];
  bpu_update_t m_out;
  int          m_drop;

  int vectors;
  int miscompares;

  bpu_update_queue #(.DEPTH(DEPTH)) dut (
    .clock                       (clock),
    .reset                       (rst),
    .in_bht_write_enable         (drv.bht_write_enable),
    .in_bht_write_index          (drv.bht_write_index),
    .in_bht_write_counter_select (drv.bht_write_counter_select),
    .in_bht_write_inc            (drv.bht_write_inc),
    .in_bht_write_dec            (drv.bht_write_dec),
    .in_bht_valid_in             (drv.bht_valid_in),
    .in_btb_we                   (drv.btb_we),
    .in_btb_wmask                (drv.btb_wmask),
    .in_btb_write_index          (drv.btb_write_index),
    .in_btb_din                  (drv.btb_din),
    .bpu_port_busy               (busy),
    .bht_write_enable            (bht_write_enable),
    .bht_write_index             (bht_write_index),
    .bht_write_counter_select    (bht_write_counter_select),
    .bht_write_inc               (bht_write_inc),
    .bht_write_dec               (bht_write_dec),
    .bht_valid_in                (bht_valid_in),
    .btb_ce                      (btb_ce),
    .btb_we                      (btb_we),
    .btb_wmask                   (btb_wmask),
    .btb_write_index             (btb_write_index),
    .btb_din                     (btb_din),
    .occupancy                   (occupancy),
    .full                        (full),
    .drop_count                  (drop_count)
  );

  assign obs = {bht_write_enable, bht_write_index, bht_write_counter_select, bht_write_inc,
                bht_write_dec, bht_valid_in, btb_we, btb_wmask, btb_write_index, btb_din};
  assign obs_vec = {obs, btb_ce, occupancy, full, drop_count};

  function automatic bpu_update_t rand_entry(int kind);
    bpu_update_t e;
    logic [159:0] r1;
    logic [159:0] r2;
    logic [1:0]   k;
    k  = 2'(kind);
    r1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom, $urandom};
    e.bht_write_enable         = k[0];
    e.bht_write_index          = 9'($urandom);
    e.bht_write_counter_select = 2'($urandom);
    e.bht_write_inc            = 1'($urandom);
    e.bht_write_dec            = 1'($urandom);
    e.bht_valid_in             = 1'($urandom);
    e.btb_we                   = k[1];
    e.btb_wmask                = r1[128:0];
    e.btb_write_index          = 9'($urandom);
    e.btb_din                  = r2[128:0];
    return e;
  endfunction

  // Reference: accept into a FIFO when there is room (a same-cycle drain frees a
  // slot), then the table port takes the oldest entry whenever it is not busy.
  task automatic tick();
    bit req;
    bit room;
    req = drv.bht_write_enable | drv.btb_we;
    if (rst) begin
      mq.delete();
      m_drop = 0;
      m_out  = '0;
    end else begin
      room = (mq.size() < DEPTH) || (mq.size() != 0 && !busy);
      if (req) begin
        if (room) mq.push_back(drv);
        else if (m_drop < 65535) m_drop++;
      end
      if (!busy && mq.size() != 0) m_out = mq.pop_front();
      else m_out = '0;
    end
    exp_vec = {m_out, m_out.btb_we, 3'(mq.size()), (mq.size() == DEPTH), 16'(m_drop)};
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    busy = 1'b0;
    drv  = rand_entry(3);
    tick();
    tick();
    vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL reset_model: got %h want %h", obs_vec, exp_vec);
    end
    vectors++;
    if ({occupancy, full, drop_count, bht_write_enable, btb_ce, btb_we} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_state: got occ=%0d full=%b drop=%0d bht_we=%b btb_ce=%b btb_we=%b want all 0",
               occupancy, full, drop_count, bht_write_enable, btb_ce, btb_we);
    end
    rst = 1'b0;
    drv = '0;
  endtask

  task automatic test_single();
    bpu_update_t e;
    e = '0;
    e.bht_write_enable         = 1'b1;
    e.bht_write_index          = 9'h1A5;
    e.bht_write_counter_select = 2'd2;
    e.bht_write_inc            = 1'b1;
    drv = e;
    tick();
    drv = '0;
    vectors++;
    if ({bht_write_enable, bht_write_index, bht_write_counter_select, bht_write_inc, btb_we}
        !== {1'b1, 9'h1A5, 2'd2, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_out: got we=%b idx=%h sel=%0d inc=%b btb_we=%b want 1 1a5 2 1 0",
               bht_write_enable, bht_write_index, bht_write_counter_select, bht_write_inc, btb_we);
    end
    vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL single_model: got %h want %h", obs_vec, exp_vec);
    end
    tick();
    vectors++;
    if (obs_vec !== '0) begin
      miscompares++;
      $display("FAIL single_idle: got %h want 0", obs_vec);
    end
  endtask

  task automatic test_busy_stall();
    bpu_update_t r[3];
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        r[i] = rand_entry($urandom_range(1, 3));
        drv  = r[i];
      end else begin
        drv = '0;
      end
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL stall_busy c%0d: got %h want %h", i, obs_vec, exp_vec);
      end
    end
    vectors++;
    if ({occupancy, bht_write_enable, btb_we, btb_ce} !== {3'd3, 3'b000}) begin
      miscompares++;
      $display("FAIL stall_hold: got occ=%0d en=%b%b%b want occ=3 en=000",
               occupancy, bht_write_enable, btb_we, btb_ce);
    end
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (obs !== ((i < 3) ? r[i] : bpu_update_t'('0))) begin
        miscompares++;
        $display("FAIL stall_order c%0d: got %h want %h", i, obs, (i < 3) ? r[i] : bpu_update_t'('0));
      end
    end
  endtask

  task automatic test_full_drop();
    bpu_update_t r[6];
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r[i] = rand_entry($urandom_range(1, 3));
      drv  = r[i];
      tick();
    end
    drv = '0;
    vectors++;
    if ({full, occupancy, drop_count} !== {1'b1, 3'd4, 16'd2}) begin
      miscompares++;
      $display("FAIL full_drop: got full=%b occ=%0d drop=%0d want 1 4 2", full, occupancy, drop_count);
    end
    busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs !== ((i < 4) ? r[i] : bpu_update_t'('0)) || obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL full_drain c%0d: got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_full_simul();
    bpu_update_t r[5];
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r[i] = rand_entry($urandom_range(1, 3));
      drv  = r[i];
      tick();
    end
    busy = 1'b0;
    r[4] = rand_entry(3);
    drv  = r[4];
    tick();
    drv = '0;
    vectors++;
    if ({occupancy, full, drop_count} !== {3'd4, 1'b1, 16'd0} || obs !== r[0]) begin
      miscompares++;
      $display("FAIL full_simul: got occ=%0d full=%b drop=%0d out=%h want 4 1 0 %h",
               occupancy, full, drop_count, obs, r[0]);
    end
    for (int i = 1; i < 6; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL full_simul_drain c%0d: got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_wrap();
    bpu_update_t e;
    busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e = rand_entry(2 + (i % 2));
      e.btb_din = {1'b1, 32'($urandom), 32'($urandom), 32'($urandom), 32'h8000_0010 + 32'(i * 4)};
      drv = e;
      tick();
      vectors++;
      if (obs !== e || drop_count !== 16'd0 || obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL wrap c%0d: got %h drop=%0d want %h drop=0", i, obs, drop_count, e);
      end
    end
    drv = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv = rand_entry($urandom_range(1, 3));
      tick();
    end
    rst  = 1'b1;
    busy = 1'b0;
    drv  = rand_entry(3);
    tick();
    rst = 1'b0;
    drv = '0;
    vectors++;
    if (obs_vec !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want 0", obs_vec);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs_vec !== '0 || obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_stale c%0d: got %h want 0", i, obs_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      busy = ($urandom_range(0, 99) < 55);
      drv  = rand_entry($urandom_range(0, 3));
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", i, obs_vec, exp_vec);
      end
    end
    rst  = 1'b0;
    busy = 1'b0;
    drv  = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_drop      = 0;
    m_out       = '0;
    rst         = 1'b1;
    busy        = 1'b0;
    drv         = '0;
    test_reset();
    test_single();
    test_busy_stall();
    test_full_drop();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
